// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared constants and types for the serial packed-BCD adder.
//   BCD_W     : width of one BCD digit
//   BCD_MAX   : largest valid decimal digit
//   BCD_CORR  : correction added when a digit sum leaves the decimal range
//   state_t   : controller states (IDLE, ADD, DONE)
//   digit_invalid() : true when a 4-bit code is not a decimal digit
// ---------------------------------------------------------------------------
package bcd_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic digit_invalid(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// bcd_serial_add_ctrl_if
// Request/result bundle between the operand source and the serial BCD adder.
//   start : request strobe (only honoured while the adder is idle)
//   a, b  : packed-BCD operands, digit 0 in bits [3:0]
//   cin   : decimal carry into digit 0
//   busy  : adder is stepping through digits
//   done  : one-cycle pulse, sum/cout/err valid
//   sum   : packed-BCD result, held until the next accepted start
//   cout  : decimal carry out of the top digit
//   err   : some operand digit was above 9
// Modports: master = operand source / result consumer, slave = adder.
// ---------------------------------------------------------------------------
interface bcd_serial_add_ctrl_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) ();

    logic                      start;
    logic [BCD_W*DIGITS-1:0]   a;
    logic [BCD_W*DIGITS-1:0]   b;
    logic                      cin;
    logic                      busy;
    logic                      done;
    logic [BCD_W*DIGITS-1:0]   sum;
    logic                      cout;
    logic                      err;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, err
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, err
    );

endinterface

// File: rtl/bcd_digit_add.sv
// ---------------------------------------------------------------------------
// bcd_digit_add
// Combinational single-digit BCD adder stage.
//   x, y : BCD digits (codes 10..15 are still added, and flagged)
//   ci   : decimal carry in
//   s    : result digit
//   co   : decimal carry out
//   bad  : x or y is not a decimal digit
// ---------------------------------------------------------------------------
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] x,
    input  logic [BCD_W-1:0] y,
    input  logic             ci,
    output logic [BCD_W-1:0] s,
    output logic             co,
    output logic             bad
);

    logic [BCD_W:0] raw;
    logic [BCD_W:0] corr;

    always_comb begin
        raw  = {1'b0, x} + {1'b0, y} + {{BCD_W{1'b0}}, ci};
        // Only the low nibble of the corrected value is kept, so the
        // overflow of raw+6 past 5 bits for invalid inputs is harmless.
        corr = raw + {1'b0, BCD_CORR};
        if (raw > {1'b0, BCD_MAX}) begin
            s  = corr[BCD_W-1:0];
            co = 1'b1;
        end else begin
            s  = raw[BCD_W-1:0];
            co = 1'b0;
        end
        bad = digit_invalid(x) | digit_invalid(y);
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_serial_add_ctrl
// Multi-digit packed-BCD adder that reuses one digit adder stage, one digit
// per clock, least-significant digit first.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bcd_serial_add_ctrl_if (start/a/b/cin in,
//           busy/done/sum/cout/err out)
// A start seen in IDLE latches the operands and carry; the ADD state then
// writes digit idx each cycle, and DONE raises done for a single cycle.
// Starts arriving in ADD or DONE are dropped.
// ---------------------------------------------------------------------------
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_serial_add_ctrl_if.slave bus
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    // Digit mux has a power-of-two number of slots so every idx code
    // selects a defined value; slots past DIGITS-1 read as zero.
    localparam int SLOTS = 1 << IDX_W;
    localparam int W     = BCD_W * DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg,   idx_next;
    logic              carry_reg, carry_next;
    logic [W-1:0]      a_reg,     a_next;
    logic [W-1:0]      b_reg,     b_next;
    logic [W-1:0]      sum_reg,   sum_next;
    logic              cout_reg,  cout_next;
    logic              err_reg,   err_next;

    logic [BCD_W-1:0]  a_dig [SLOTS];
    logic [BCD_W-1:0]  b_dig [SLOTS];
    logic [BCD_W-1:0]  cur_a;
    logic [BCD_W-1:0]  cur_b;
    logic [BCD_W-1:0]  dig_s;
    logic              dig_co;
    logic              dig_bad;

    // Unpack the operand registers into digit slots for the idx mux.
    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_dig
            if (gi < DIGITS) begin : g_real
                assign a_dig[gi] = a_reg[gi*BCD_W +: BCD_W];
                assign b_dig[gi] = b_reg[gi*BCD_W +: BCD_W];
            end else begin : g_pad
                assign a_dig[gi] = '0;
                assign b_dig[gi] = '0;
            end
        end
    endgenerate

    assign cur_a = a_dig[idx_reg];
    assign cur_b = b_dig[idx_reg];

    bcd_digit_add u_digit (
        .x   (cur_a),
        .y   (cur_b),
        .ci  (carry_reg),
        .s   (dig_s),
        .co  (dig_co),
        .bad (dig_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            carry_reg <= carry_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sum_reg   <= sum_next;
            cout_reg  <= cout_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        carry_next = carry_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sum_next   = sum_reg;
        cout_next  = cout_reg;
        err_next   = err_reg;

        unique case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    a_next     = bus.a;
                    b_next     = bus.b;
                    carry_next = bus.cin;
                    idx_next   = '0;
                    sum_next   = '0;
                    cout_next  = 1'b0;
                    err_next   = 1'b0;
                    state_next = ADD;
                end
            end

            ADD: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_reg == IDX_W'(i)) begin
                        sum_next[i*BCD_W +: BCD_W] = dig_s;
                    end
                end
                carry_next = dig_co;
                err_next   = err_reg | dig_bad;
                if (idx_reg == LAST_IDX) begin
                    cout_next  = dig_co;
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_reg == ADD);
    assign bus.done = (state_reg == DONE);
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
    assign bus.err  = err_reg;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_serial_add_ctrl
// Bench for bcd_serial_add_ctrl: a 4-digit instance driven from a vector
// table plus hand-written multi-cycle sequences, and a 1-digit instance
// swept over all decimal operand pairs with start held high.
// ---------------------------------------------------------------------------
module tb_bcd_serial_add_ctrl;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bcd_serial_add_ctrl_if #(.DIGITS(4)) if4 ();
    bcd_serial_add_ctrl_if #(.DIGITS(1)) if1 ();

    bcd_serial_add_ctrl #(.DIGITS(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    bcd_serial_add_ctrl #(.DIGITS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    int total = 0;
    int bad   = 0;
    int done4_cnt = 0;

    vec_t vecs[8];

    always @(posedge clk) begin
        if (if4.done === 1'b1) done4_cnt <= done4_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for done on the 4-digit instance; returns negedges waited.
    task automatic wait_done4(output int cycles);
        cycles = 0;
        while (if4.done !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_op4(input vec_t v, input string tag);
        int cycles;
        @(negedge clk);
        if4.a     = v.a;
        if4.b     = v.b;
        if4.cin   = v.cin;
        if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        check({tag, ".busy_after_accept"}, if4.busy, 1);
        check({tag, ".no_early_done"}, if4.done, 0);
        wait_done4(cycles);
        check({tag, ".latency"}, cycles, 4);
        check({tag, ".sum"}, if4.sum, v.sum);
        check({tag, ".cout"}, if4.cout, v.cout);
        check({tag, ".err"}, if4.err, v.err);
        check({tag, ".busy_at_done"}, if4.busy, 0);
        $display("op %s: a=%h b=%h cin=%0d -> sum=%h cout=%0d err=%0d (want %h %0d %0d)",
                 tag, v.a, v.b, v.cin, if4.sum, if4.cout, if4.err, v.sum, v.cout, v.err);
        @(negedge clk);
        check({tag, ".done_one_cycle"}, if4.done, 0);
    endtask

    initial begin
        int cycles;
        int d0;
        int s;

        vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
        vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[3] = '{16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1};
        vecs[4] = '{16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0};
        vecs[5] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
        vecs[6] = '{16'h0FF0, 16'h0000, 1'b0, 16'h1650, 1'b0, 1'b1};
        vecs[7] = '{16'h4821, 16'h3179, 1'b0, 16'h8000, 1'b0, 1'b0};

        rst_n     = 1'b0;
        if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.busy", if4.busy, 0);
        check("reset.done", if4.done, 0);
        check("reset.sum",  if4.sum, 0);
        check("reset.cout", if4.cout, 0);
        check("reset.err",  if4.err, 0);
        check("reset.d1_busy", if1.busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven operations on the 4-digit instance.
        for (int i = 0; i < 8; i++) begin
            run_op4(vecs[i], $sformatf("vec%0d", i));
        end

        // Start re-pulsed in ADD (with new operands) and in DONE: ignored.
        @(negedge clk);
        d0 = done4_cnt;
        if4.a = 16'h1234; if4.b = 16'h5678; if4.cin = 1'b0; if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        @(negedge clk);
        if4.a = 16'h9999; if4.b = 16'h9999; if4.cin = 1'b1; if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        wait_done4(cycles);
        check("ign.done_seen", if4.done, 1);
        check("ign.sum", if4.sum, 16'h6912);
        check("ign.cout", if4.cout, 0);
        if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        check("ign.busy_after_done", if4.busy, 0);
        check("ign.done_after_done", if4.done, 0);
        check("ign.sum_held", if4.sum, 16'h6912);
        repeat (3) @(negedge clk);
        check("ign.still_idle", if4.busy, 0);
        check("ign.one_done_pulse", done4_cnt - d0, 1);
        check("ign.sum_stable", if4.sum, 16'h6912);
        $display("op ignore-start: sum=%h dones=%0d", if4.sum, done4_cnt - d0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        d0 = done4_cnt;
        if4.a = 16'h1234; if4.b = 16'h5678; if4.cin = 1'b0; if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst.partial_sum", if4.sum, 16'h0012);
        rst_n = 1'b0;
        #1;
        check("rst.busy", if4.busy, 0);
        check("rst.sum", if4.sum, 0);
        check("rst.cout", if4.cout, 0);
        check("rst.done", if4.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rst.no_done", done4_cnt - d0, 0);
        check("rst.idle", if4.busy, 0);
        $display("op mid-reset: sum=%h busy=%0d dones=%0d", if4.sum, if4.busy, done4_cnt - d0);
        run_op4(vecs[0], "after_rst");

        // Exhaustive 1-digit sweep with start held high throughout.
        @(negedge clk);
        if1.a = 4'd0; if1.b = 4'd0; if1.cin = 1'b0; if1.start = 1'b1;
        for (int n = 0; n < 200; n++) begin
            cycles = 0;
            do begin
                @(negedge clk);
                cycles++;
            end while (if1.done !== 1'b1 && cycles < 10);
            s = (n / 20) + ((n / 2) % 10) + (n % 2);
            check("d1.interval", cycles, (n == 0) ? 2 : 3);
            check("d1.sum", if1.sum, s % 10);
            check("d1.cout", if1.cout, (s >= 10) ? 1 : 0);
            check("d1.err", if1.err, 0);
            $display("op d1: %0d+%0d+%0d -> sum=%0d cout=%0d gap=%0d",
                     n / 20, (n / 2) % 10, n % 2, if1.sum, if1.cout, cycles);
            if (n < 199) begin
                if1.a   = 4'((n + 1) / 20);
                if1.b   = 4'(((n + 1) / 2) % 10);
                if1.cin = 1'((n + 1) % 2);
            end else begin
                if1.start = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        check("d1.idle_at_end", if1.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
